// File: rtl/player_updater.sv
// Player position/heading updater: applies turn and move switches on each start,
// then checks the trial position against the level grid one axis at a time so the player slides along walls.
module player_updater #(
    parameter int TURN_SPEED = 4,
    parameter int MOVE_SPEED = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    input  logic        turn_right,
    input  logic        turn_left,
    input  logic        move_forward,
    input  logic        move_backward,
    input  logic [13:0] cur_pos_x,
    input  logic [12:0] cur_pos_y,
    input  logic [7:0]  cur_angle,
    output logic [13:0] next_pos_x,
    output logic [12:0] next_pos_y,
    output logic [7:0]  next_angle,
    output logic [5:0]  grid_x,
    output logic [4:0]  grid_y,
    input  logic [2:0]  grid_out
);

    typedef enum logic [2:0] {IDLE, CALC, RDX, CHKX, RDY, CHKY, DONE} state_t;

    // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
    localparam logic [6:0] SIN_Q [0:64] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,  31,  34,  37,  40,  43,  46,
         49,  51,  54,  57,  60,  63,  65,  68,  71,  73,  76,  78,  81,  83,  85,  88,
         90,  92,  94,  96,  98, 100, 102, 104, 106, 107, 109, 110, 112, 113, 115, 116,
        117, 118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127,
        127
    };

    function automatic logic signed [7:0] sin_lut(input logic [7:0] ang);
        logic [6:0] idx;
        logic [6:0] mag;
        idx = ang[6] ? 7'd64 - {1'b0, ang[5:0]} : {1'b0, ang[5:0]};
        mag = SIN_Q[idx];
        return ang[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    state_t              state_q, state_d;
    logic [13:0]         cur_x_q, cur_x_d;
    logic [12:0]         cur_y_q, cur_y_d;
    logic [7:0]          angle_q, angle_d;
    logic                fwd_q, fwd_d;
    logic                bwd_q, bwd_d;
    logic [14:0]         cand_x_q, cand_x_d;
    logic [13:0]         cand_y_q, cand_y_d;
    logic [13:0]         acc_x_q, acc_x_d;
    logic [13:0]         next_pos_x_q, next_pos_x_d;
    logic [12:0]         next_pos_y_q, next_pos_y_d;
    logic [7:0]          next_angle_q, next_angle_d;

    logic signed [7:0]   cos_v, sin_v;
    logic signed [15:0]  mul_x, mul_y;
    logic signed [7:0]   dx, dy, step_x, step_y;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = start ? CALC : IDLE;
            CALC:    state_d = RDX;
            RDX:     state_d = CHKX;
            CHKX:    state_d = RDY;
            RDY:     state_d = CHKY;
            CHKY:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done   = 1'b0;
        grid_x = '0;
        grid_y = '0;
        unique case (state_q)
            RDX, CHKX: begin
                grid_x = cand_x_q[13:8];
                grid_y = cur_y_q[12:8];
            end
            RDY, CHKY: begin
                grid_x = acc_x_q[13:8];
                grid_y = cand_y_q[12:8];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        angle_d      = angle_q;
        fwd_d        = fwd_q;
        bwd_d        = bwd_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        acc_x_d      = acc_x_q;
        next_pos_x_d = next_pos_x_q;
        next_pos_y_d = next_pos_y_q;
        next_angle_d = next_angle_q;

        cos_v  = sin_lut(angle_q + 8'd64);
        sin_v  = sin_lut(angle_q);
        mul_x  = 16'(cos_v) * 16'(MOVE_SPEED);
        mul_y  = 16'(sin_v) * 16'(MOVE_SPEED);
        dx     = 8'(mul_x >>> 7);
        dy     = 8'(mul_y >>> 7);
        step_x = fwd_q ? dx : (bwd_q ? -dx : 8'sd0);
        step_y = fwd_q ? dy : (bwd_q ? -dy : 8'sd0);

        unique case (state_q)
            IDLE: if (start) begin
                cur_x_d = cur_pos_x;
                cur_y_d = cur_pos_y;
                fwd_d   = move_forward & ~move_backward;
                bwd_d   = move_backward & ~move_forward;
                unique case ({turn_right, turn_left})
                    2'b10:   angle_d = cur_angle + 8'(TURN_SPEED);
                    2'b01:   angle_d = cur_angle - 8'(TURN_SPEED);
                    default: angle_d = cur_angle;
                endcase
            end
            // The extra top bit flags both underflow (wraps high) and overflow past the map edge.
            CALC: begin
                cand_x_d = {1'b0, cur_x_q} + 15'(step_x);
                cand_y_d = {1'b0, cur_y_q} + 14'(step_y);
            end
            CHKX: acc_x_d = (!cand_x_q[14] && grid_out == 3'd0) ? cand_x_q[13:0] : cur_x_q;
            CHKY: begin
                next_pos_x_d = acc_x_q;
                next_pos_y_d = (!cand_y_q[13] && grid_out == 3'd0) ? cand_y_q[12:0] : cur_y_q;
                next_angle_d = angle_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            angle_q      <= '0;
            fwd_q        <= 1'b0;
            bwd_q        <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            acc_x_q      <= '0;
            next_pos_x_q <= '0;
            next_pos_y_q <= '0;
            next_angle_q <= '0;
        end else begin
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            angle_q      <= angle_d;
            fwd_q        <= fwd_d;
            bwd_q        <= bwd_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            acc_x_q      <= acc_x_d;
            next_pos_x_q <= next_pos_x_d;
            next_pos_y_q <= next_pos_y_d;
            next_angle_q <= next_angle_d;
        end
    end

    assign next_pos_x = next_pos_x_q;
    assign next_pos_y = next_pos_y_q;
    assign next_angle = next_angle_q;

endmodule

// File: tb/tb_player_updater.sv
// Self-checking bench for player_updater: directed cases plus random operations
// compared against a real-arithmetic reference model and a 1-cycle-latency grid RAM.
module tb_player_updater;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        turn_right, turn_left, move_forward, move_backward;
    logic [13:0] cur_pos_x;
    logic [12:0] cur_pos_y;
    logic [7:0]  cur_angle;
    logic [13:0] next_pos_x;
    logic [12:0] next_pos_y;
    logic [7:0]  next_angle;
    logic [5:0]  grid_x;
    logic [4:0]  grid_y;
    logic [2:0]  grid_out = 3'd0;

    logic [2:0]  grid [0:31][0:63];

    int checks   = 0;
    int failures = 0;
    int prev_nx  = 0;
    int prev_ny  = 0;
    int prev_na  = 0;

    player_updater #(.TURN_SPEED(4), .MOVE_SPEED(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .done          (done),
        .turn_right    (turn_right),
        .turn_left     (turn_left),
        .move_forward  (move_forward),
        .move_backward (move_backward),
        .cur_pos_x     (cur_pos_x),
        .cur_pos_y     (cur_pos_y),
        .cur_angle     (cur_angle),
        .next_pos_x    (next_pos_x),
        .next_pos_y    (next_pos_y),
        .next_angle    (next_angle),
        .grid_x        (grid_x),
        .grid_y        (grid_y),
        .grid_out      (grid_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) grid_out <= grid[grid_y][grid_x];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_grid();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++)
                grid[r][c] = 3'd0;
    endtask

    task automatic random_grid();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++)
                grid[r][c] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    endtask

    // Reference: trig from real cos/sin, floor-scaled step, then axis-by-axis wall test.
    task automatic model(input int cx, input int cy, input int ca,
                         input bit r, input bit l, input bit f, input bit b,
                         output int nx, output int ny, output int na,
                         output int rx1, output int ry1, output int rx2, output int ry2);
        int  delta, c, s, dx, dy, dir, candx, candy;
        real th;
        delta = (r && !l) ? 4 : ((l && !r) ? -4 : 0);
        na    = (ca + delta + 256) % 256;
        th    = 2.0 * 3.14159265358979 * na / 256.0;
        c     = int'(127.0 * $cos(th));
        s     = int'(127.0 * $sin(th));
        dx    = int'($floor(c * 32 / 128.0));
        dy    = int'($floor(s * 32 / 128.0));
        dir   = (f && !b) ? 1 : ((b && !f) ? -1 : 0);
        candx = cx + dir * dx;
        candy = cy + dir * dy;
        rx1   = (((candx + 32768) % 32768) / 256) % 64;
        ry1   = cy / 256;
        nx    = (candx >= 0 && candx <= 16383 && grid[cy / 256][candx / 256] == 3'd0) ? candx : cx;
        rx2   = nx / 256;
        ry2   = (((candy + 16384) % 16384) / 256) % 32;
        ny    = (candy >= 0 && candy <= 8191 && grid[candy / 256][nx / 256] == 3'd0) ? candy : cy;
    endtask

    task automatic run_op(input int cx, input int cy, input int ca,
                          input bit r, input bit l, input bit f, input bit b, input bit poke);
        int nx, ny, na, rx1, ry1, rx2, ry2, pulses;
        model(cx, cy, ca, r, l, f, b, nx, ny, na, rx1, ry1, rx2, ry2);
        @(negedge clock);
        cur_pos_x = 14'(cx); cur_pos_y = 13'(cy); cur_angle = 8'(ca);
        turn_right = r; turn_left = l; move_forward = f; move_backward = b;
        start = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                start = 1'b0;
                cur_pos_x = 14'($urandom); cur_pos_y = 13'($urandom); cur_angle = 8'($urandom);
                turn_right = 1'($urandom); turn_left = 1'($urandom);
                move_forward = 1'($urandom); move_backward = 1'($urandom);
            end
            check("done_timing", done, int'(cyc == 6));
            if (cyc == 2 || cyc == 3) begin
                check("rd1_x", grid_x, rx1);
                check("rd1_y", grid_y, ry1);
            end
            if (cyc == 3 && poke) start = 1'b1;
            if (cyc == 4) begin
                start = 1'b0;
                check("hold_nx", next_pos_x, prev_nx);
                check("hold_na", next_angle, prev_na);
            end
            if (cyc == 4 || cyc == 5) begin
                check("rd2_x", grid_x, rx2);
                check("rd2_y", grid_y, ry2);
            end
            if (cyc == 6) begin
                check("next_x", next_pos_x, nx);
                check("next_y", next_pos_y, ny);
                check("next_a", next_angle, na);
            end
        end
        prev_nx = nx; prev_ny = ny; prev_na = na;
        @(negedge clock);
        check("idle_done", done, 0);
        check("idle_gx", grid_x, 0);
        check("idle_gy", grid_y, 0);
        check("idle_ny", next_pos_y, prev_ny);
        if (poke) begin
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clock);
                if (done) pulses++;
            end
            check("poke_extra_done", pulses, 0);
        end
    endtask

    task automatic reset_mid_op();
        int pulses;
        @(negedge clock);
        cur_pos_x = 14'd384; cur_pos_y = 13'd384; cur_angle = 8'd32;
        turn_right = 1'b1; turn_left = 1'b0; move_forward = 1'b1; move_backward = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_done", done, 0);
        check("rst_nx", next_pos_x, 0);
        check("rst_ny", next_pos_y, 0);
        check("rst_na", next_angle, 0);
        check("rst_gx", grid_x, 0);
        check("rst_gy", grid_y, 0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("rst_no_done", pulses, 0);
        prev_nx = 0; prev_ny = 0; prev_na = 0;
    endtask

    initial begin
        int cx, cy;
        reset = 1'b1; start = 1'b0;
        turn_right = 1'b0; turn_left = 1'b0; move_forward = 1'b0; move_backward = 1'b0;
        cur_pos_x = '0; cur_pos_y = '0; cur_angle = '0;
        clear_grid();
        repeat (3) @(negedge clock);
        check("reset_done", done, 0);
        check("reset_nx", next_pos_x, 0);
        check("reset_ny", next_pos_y, 0);
        check("reset_na", next_angle, 0);
        check("reset_gx", grid_x, 0);
        check("reset_gy", grid_y, 0);
        reset = 1'b0;

        run_op(384, 384, 0, 0, 0, 1, 0, 0);
        run_op(384, 384, 0, 1, 0, 1, 0, 0);
        run_op(384, 384, 0, 0, 1, 0, 0, 0);
        run_op(384, 384, 0, 1, 1, 0, 0, 0);
        run_op(384, 384, 255, 1, 0, 0, 0, 0);
        run_op(384, 384, 0, 0, 0, 0, 1, 0);
        run_op(384, 384, 0, 0, 0, 1, 1, 0);
        run_op(10, 384, 0, 0, 0, 0, 1, 0);
        run_op(16380, 384, 0, 0, 0, 1, 0, 0);
        run_op(384, 8190, 64, 0, 0, 1, 0, 0);
        grid[1][2] = 3'd5;
        run_op(500, 384, 0, 0, 0, 1, 0, 0);
        run_op(500, 384, 32, 0, 0, 1, 0, 0);
        run_op(500, 384, 32, 0, 0, 1, 0, 1);
        reset_mid_op();
        run_op(384, 384, 0, 0, 0, 1, 0, 0);

        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) random_grid();
            case ($urandom_range(0, 3))
                0:       cx = $urandom_range(0, 40);
                1:       cx = 16383 - $urandom_range(0, 40);
                default: cx = $urandom_range(0, 16383);
            endcase
            case ($urandom_range(0, 3))
                0:       cy = $urandom_range(0, 40);
                1:       cy = 8191 - $urandom_range(0, 40);
                default: cy = $urandom_range(0, 8191);
            endcase
            run_op(cx, cy, $urandom_range(0, 255), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_updater.md
Name: player_updater

Overview:
- Responder to the main FSM's start/done handshake.
- On each start it samples the player state and the turn/move switches, and computes the new angle and a trial position.
- It checks collisions against the 64x32 level grid on the shared read port, one axis at a time so the player slides along walls.
- It presents next position and angle for the FSM's store step.

Parameters:
TURN_SPEED, 4, angle increment per update (256 units per revolution)
MOVE_SPEED, 32, forward step scale; displacement = (trig * MOVE_SPEED) >>> 7

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
start  input  1  one-cycle request from FSM
done  output  1  one-cycle completion pulse
turn_right  input  1  switch, sampled at start
turn_left  input  1  switch, sampled at start
move_forward  input  1  switch, sampled at start
move_backward  input  1  switch, sampled at start
cur_pos_x  input  14  current x, 6.8 fixed point (cell = bits 13:8)
cur_pos_y  input  13  current y, 5.8 fixed point (cell = bits 12:8)
cur_angle  input  8  current heading; 0 = +x, 64 = +y
next_pos_x  output  14  updated x
next_pos_y  output  13  updated y
next_angle  output  8  updated heading
grid_x  output  6  grid read column
grid_y  output  5  grid read row
grid_out  input  3  grid cell contents; 0 = empty, nonzero = blocked

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- Reset, including mid-operation:
  - state goes to IDLE; done=0.
  - next_pos_x=0, next_pos_y=0, next_angle=0.
  - grid_x=0, grid_y=0.
- States: IDLE -> CALC -> RDX -> CHKX -> RDY -> CHKY -> DONE -> IDLE. Latency is fixed whatever the inputs.
- IDLE:
  - On start=1, latch the cur_* inputs and the four switches.
  - Angle: a = cur_angle + TURN_SPEED if right only; cur_angle - TURN_SPEED if left only; otherwise unchanged. Mod 256.
  - Go to CALC.
  - start is ignored in every other state.
- CALC:
  - Look up C = round(127*cos(2*pi*a/256)) and S = round(127*sin(...)), signed 8-bit, from an internal combinational LUT.
  - dx = (C*MOVE_SPEED)>>>7 and dy = (S*MOVE_SPEED)>>>7, arithmetic (floor).
  - Forward only: use +dx, +dy. Backward only: use -dx, -dy. Neither or both: displacement is 0.
  - Form cand_x and cand_y at 15/14 bits.
  - oob_x is set if cand_x < 0 or cand_x > 16383. oob_y is set if cand_y < 0 or cand_y > 8191.
- RDX: grid_x = cand_x[13:8], grid_y = cur_y[12:8]. Grid RAM has 1-cycle read latency.
- CHKX:
  - Hold the RDX address.
  - acc_x = cand_x if (!oob_x && grid_out==0), else cur_x.
- RDY: grid_x = acc_x[13:8], grid_y = cand_y[12:8].
- CHKY:
  - Hold the RDY address.
  - acc_y = cand_y if (!oob_y && grid_out==0), else cur_y.
  - Register next_pos_x=acc_x, next_pos_y=acc_y, next_angle=a.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing: with start in cycle 0, done is high in cycle 6.
- Outputs between operations:
  - next_* are stable from DONE until the next CHKY.
  - grid_x and grid_y are 0 outside RDX/CHKX/RDY/CHKY.
- Zero displacement still performs both reads; the position is unchanged unless the current cell itself is blocked, in which case it is also unchanged.
- Start must never re-trigger the block while it is busy.
- Angle wraps mod 256 (255+4 -> 3; 0-4 -> 252).

Test Plan:
- Open grid, pos (384,384), angle 0, forward, start -> done in cycle 6; next = (415,384,0); grid reads (1,1) then (1,1).
- Wall at cell (2,1), pos (500,384), angle 0, forward -> next_pos_x=500 (cand 531 blocked), next_pos_y=384.
- Same wall, pos (500,384), angle 32 (C=S=90, d=22), forward -> slide: next = (500,406,32); reads (2,1) then (1,1).
- Turns:
  - Angle 0, turn_right + forward, open grid: next_angle=4, C=126, S=12 -> next = (415,387,4).
  - turn_left from 0 -> next_angle=252.
  - Both turn switches -> next_angle=0.
- Boundaries:
  - pos (10,384), angle 0, backward -> cand -21 is oob, next_pos_x=10.
  - pos (16380,384), forward -> oob, next_pos_x=16380.
  - backward from (384,384) -> next_pos_x=353.
- Handshake and reset:
  - Reset asserted in RDY -> done never pulses; outputs all 0.
  - A start pulse during CHKX is ignored; exactly one done.
  - A new start after DONE produces a second, correct result.
